gpio_ctrl: RTL and testbench

Parametrised successor to the simple output-only GPIO: drives up to 32 outputs and samples up to 32 inputs through two-flop synchronisers, an optional per-bit debounce filter and edge detection with maskable, sticky interrupt status. Sits on the same device bus as the other memory-mapped peripherals: one request per cycle, read data one cycle later. `irq_o` feeds the system interrupt controller.

---
 rtl/gpio_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gpio_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO; drives gp_o, samples gp_i through a 2-flop synchroniser,
//   an optional debounce filter and edge detection into sticky, maskable interrupt status.
// Latency: device_rvalid_o/device_rdata_o one cycle after device_req_i; gp_i -> IN two edges,
//   -> irq_o three edges (plus DBNC_CYCLES edges when debounce is built in and nonzero).
// Backpressure: none; one request accepted every cycle, the response always follows next cycle.
//
// Ports: clk_i, rst_ni (async active-low) | device_req_i/addr/we/be/wdata request,
//        device_rvalid_o/rdata_o response | gp_o output pins | gp_i async input pins |
//        irq_o = OR of IRQ_STATUS.
// Build option: `define GPIO_CTRL_DEBOUNCE_EN adds per-input debounce counters and the
//        DBNC_CYCLES register at 0x1C; without it IN is the synchroniser output and 0x1C is unmapped.
module gpio_ctrl #(
    parameter int unsigned GpoWidth  = 16,
    parameter int unsigned GpiWidth  = 16,
    parameter int unsigned DbncWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    output logic [GpoWidth-1:0] gp_o,
    input  logic [GpiWidth-1:0] gp_i,
    output logic                irq_o
);

    // Word indices decoded from addr[9:2]
    localparam logic [7:0] RegOut    = 8'h00;
    localparam logic [7:0] RegOutSet = 8'h01;
    localparam logic [7:0] RegOutClr = 8'h02;
    localparam logic [7:0] RegIn     = 8'h03;
    localparam logic [7:0] RegRiseEn = 8'h04;
    localparam logic [7:0] RegFallEn = 8'h05;
    localparam logic [7:0] RegStatus = 8'h06;
    localparam logic [7:0] RegDbnc   = 8'h07;

    logic [7:0]  reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] be_mask;
    logic [31:0] wdata_m;

    assign reg_idx = device_addr_i[9:2];
    assign wr_en   = device_req_i & device_we_i;
    assign rd_en   = device_req_i & ~device_we_i;
    assign be_mask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                      {8{device_be_i[1]}}, {8{device_be_i[0]}}};
    // Byte-masked write data; SET, CLR and W1C only ever act on enabled lanes.
    assign wdata_m = device_wdata_i & be_mask;

    // Address bits outside [9:2] and data bits above the register widths are don't-care.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{device_addr_i[31:10], device_addr_i[1:0], wdata_m, be_mask};

    logic [GpoWidth-1:0] out_q,     out_d;
    logic [GpiWidth-1:0] rise_en_q, rise_en_d;
    logic [GpiWidth-1:0] fall_en_q, fall_en_d;
    logic [GpiWidth-1:0] status_q,  status_d;
    logic [GpiWidth-1:0] sync1_q,   sync2_q;
    logic [GpiWidth-1:0] in_val;     // filtered input value (IN)
    logic [GpiWidth-1:0] in_prev_q;  // IN one cycle earlier, for edge detection
    logic [GpiWidth-1:0] edge_set;
    logic [GpiWidth-1:0] w1c;
    logic [31:0]         rdata_d,   rdata_q;
    logic                rvalid_q;

`ifdef GPIO_CTRL_DEBOUNCE_EN
    logic [DbncWidth-1:0] dbnc_q, dbnc_d;
    logic [GpiWidth-1:0]  filt_q;
    logic [DbncWidth-1:0] cnt_q [GpiWidth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbnc_q <= '0;
            filt_q <= '0;
            for (int i = 0; i < GpiWidth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dbnc_q <= dbnc_d;
            for (int i = 0; i < GpiWidth; i++) begin
                if (dbnc_q == '0) begin
                    // Bypass: load what sync2 is about to hold, so filt_q always equals s2
                    // and switching the filter on later starts from the current input.
                    filt_q[i] <= sync1_q[i];
                    cnt_q[i]  <= '0;
                end else if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= dbnc_q - DbncWidth'(1)) begin
                    // >= rather than == also catches a count left above a newly lowered length.
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DbncWidth'(1);
                end
            end
        end
    end

    assign in_val = filt_q;
`else
    // Debounce width only sizes hardware that this build leaves out.
    logic [DbncWidth-1:0] unused_dbnc;
    assign unused_dbnc = '0;

    assign in_val = sync2_q;
`endif

    assign edge_set = (rise_en_q &  in_val & ~in_prev_q)
                    | (fall_en_q & ~in_val &  in_prev_q);

    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
`ifdef GPIO_CTRL_DEBOUNCE_EN
        dbnc_d    = dbnc_q;
`endif
        if (wr_en) begin
            case (reg_idx)
                RegOut:    out_d     = (out_q & ~be_mask[GpoWidth-1:0]) | wdata_m[GpoWidth-1:0];
                RegOutSet: out_d     = out_q | wdata_m[GpoWidth-1:0];
                RegOutClr: out_d     = out_q & ~wdata_m[GpoWidth-1:0];
                RegRiseEn: rise_en_d = (rise_en_q & ~be_mask[GpiWidth-1:0]) | wdata_m[GpiWidth-1:0];
                RegFallEn: fall_en_d = (fall_en_q & ~be_mask[GpiWidth-1:0]) | wdata_m[GpiWidth-1:0];
                RegStatus: w1c       = wdata_m[GpiWidth-1:0];
`ifdef GPIO_CTRL_DEBOUNCE_EN
                RegDbnc:   dbnc_d    = (dbnc_q & ~be_mask[DbncWidth-1:0]) | wdata_m[DbncWidth-1:0];
`endif
                default: ;
            endcase
        end
        // A new edge in the same cycle as its W1C keeps the flag set.
        status_d = (status_q & ~w1c) | edge_set;
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (reg_idx)
                RegOut, RegOutSet, RegOutClr: rdata_d = 32'(out_q);
                RegIn:     rdata_d = 32'(in_val);
                RegRiseEn: rdata_d = 32'(rise_en_q);
                RegFallEn: rdata_d = 32'(fall_en_q);
                RegStatus: rdata_d = 32'(status_q);
`ifdef GPIO_CTRL_DEBOUNCE_EN
                RegDbnc:   rdata_d = 32'(dbnc_q);
`endif
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            in_prev_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            sync1_q   <= gp_i;
            sync2_q   <= sync1_q;
            in_prev_q <= in_val;
            rdata_q   <= rdata_d;
            rvalid_q  <= device_req_i;
        end
    end

    assign gp_o            = out_q;
    assign irq_o           = |status_q;
    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed plus randomised bus/pin stimulus against a per-edge reference model.
// Latency: not applicable (testbench).
// Backpressure: not applicable (testbench).
module tb_gpio_ctrl;

    localparam int GPO_W  = 16;
    localparam int GPI_W  = 16;
    localparam int DBNC_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             device_req_i;
    logic [31:0]      device_addr_i;
    logic             device_we_i;
    logic [3:0]       device_be_i;
    logic [31:0]      device_wdata_i;
    logic             device_rvalid_o;
    logic [31:0]      device_rdata_o;
    logic [GPO_W-1:0] gp_o;
    logic [GPI_W-1:0] gp_i;
    logic             irq_o;

    always #5 clk_i = ~clk_i;

    gpio_ctrl #(.GpoWidth(GPO_W), .GpiWidth(GPI_W), .DbncWidth(DBNC_W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .device_req_i   (device_req_i),
        .device_addr_i  (device_addr_i),
        .device_we_i    (device_we_i),
        .device_be_i    (device_be_i),
        .device_wdata_i (device_wdata_i),
        .device_rvalid_o(device_rvalid_o),
        .device_rdata_o (device_rdata_o),
        .gp_o           (gp_o),
        .gp_i           (gp_i),
        .irq_o          (irq_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state, expressed in register-map terms.
    logic [GPO_W-1:0] m_out;
    logic [GPI_W-1:0] m_rise, m_fall, m_status;
    logic [GPI_W-1:0] m_in;       // IN as visible now
    logic [GPI_W-1:0] m_in_last;  // IN one cycle ago
    logic [GPI_W-1:0] hist[$];    // pin values presented before each edge since reset
`ifdef GPIO_CTRL_DEBOUNCE_EN
    logic [DBNC_W-1:0] m_dbnc;
    int                run [GPI_W];  // consecutive cycles s2 has disagreed with IN
`endif
    logic [GPI_W-1:0] gp_cur;
    logic [31:0]      last_rdata;

    function automatic logic [GPI_W-1:0] hist_at(input int n);
        int idx;
        idx = hist.size() - 1 - n;
        if (idx < 0) return '0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        m_out = '0; m_rise = '0; m_fall = '0; m_status = '0;
        m_in = '0; m_in_last = '0;
        hist.delete();
`ifdef GPIO_CTRL_DEBOUNCE_EN
        m_dbnc = '0;
        for (int i = 0; i < GPI_W; i++) run[i] = 0;
`endif
    endtask

    // One clock: present a request and the current pins, advance the model, check outputs.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0]      mask, wm, exp_rdata;
        logic [GPI_W-1:0] edges, w1c, in_new;
        logic [7:0]       w;
`ifdef GPIO_CTRL_DEBOUNCE_EN
        logic [GPI_W-1:0] s2b;
`endif
        device_req_i   = req;
        device_we_i    = we;
        device_addr_i  = addr;
        device_be_i    = be;
        device_wdata_i = wdata;
        gp_i           = gp_cur;
        @(posedge clk_i);
        w    = addr[9:2];
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wm   = wdata & mask;
        exp_rdata = 32'h0;
        if (req && !we) begin
            case (w)
                8'd0, 8'd1, 8'd2: exp_rdata = 32'(m_out);
                8'd3: exp_rdata = 32'(m_in);
                8'd4: exp_rdata = 32'(m_rise);
                8'd5: exp_rdata = 32'(m_fall);
                8'd6: exp_rdata = 32'(m_status);
`ifdef GPIO_CTRL_DEBOUNCE_EN
                8'd7: exp_rdata = 32'(m_dbnc);
`endif
                default: exp_rdata = 32'h0;
            endcase
        end
        edges = (m_rise & m_in & ~m_in_last) | (m_fall & ~m_in & m_in_last);
        hist.push_back(gp_cur);
        if (hist.size() > 4) void'(hist.pop_front());
`ifdef GPIO_CTRL_DEBOUNCE_EN
        if (m_dbnc == 0) begin
            in_new = hist_at(1);
            for (int i = 0; i < GPI_W; i++) run[i] = 0;
        end else begin
            s2b    = hist_at(2);
            in_new = m_in;
            for (int i = 0; i < GPI_W; i++) begin
                if (s2b[i] != m_in[i]) begin
                    run[i]++;
                    if (run[i] >= int'(m_dbnc)) begin
                        in_new[i] = s2b[i];
                        run[i]    = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
`else
        in_new = hist_at(1);
`endif
        w1c = '0;
        if (req && we) begin
            case (w)
                8'd0: m_out  = (m_out & ~mask[GPO_W-1:0]) | wm[GPO_W-1:0];
                8'd1: m_out  = m_out | wm[GPO_W-1:0];
                8'd2: m_out  = m_out & ~wm[GPO_W-1:0];
                8'd4: m_rise = (m_rise & ~mask[GPI_W-1:0]) | wm[GPI_W-1:0];
                8'd5: m_fall = (m_fall & ~mask[GPI_W-1:0]) | wm[GPI_W-1:0];
                8'd6: w1c    = wm[GPI_W-1:0];
`ifdef GPIO_CTRL_DEBOUNCE_EN
                8'd7: m_dbnc = (m_dbnc & ~mask[DBNC_W-1:0]) | wm[DBNC_W-1:0];
`endif
                default: ;
            endcase
        end
        m_status  = (m_status & ~w1c) | edges;
        m_in_last = m_in;
        m_in      = in_new;
        #1;
        chk("gp_o", 32'(gp_o), 32'(m_out));
        chk("irq_o", 32'(irq_o), 32'(|m_status));
        chk("rvalid", 32'(device_rvalid_o), 32'(req));
        if (req) chk("rdata", device_rdata_o, exp_rdata);
        last_rdata = device_rdata_o;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
        step(1'b1, 1'b1, addr, be, d);
    endtask

    task automatic rd(input logic [31:0] addr);
        step(1'b1, 1'b0, addr, 4'hF, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_ni         = 1'b0;
        device_req_i   = 1'b0;
        device_we_i    = 1'b0;
        device_addr_i  = 32'h0;
        device_be_i    = 4'h0;
        device_wdata_i = 32'h0;
        gp_i           = gp_cur;
        #1;
        chk("rst_gp_o", 32'(gp_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_rvalid", 32'(device_rvalid_o), 32'h0);
        chk("rst_rdata", device_rdata_o, 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_ni = 1'b1;
        gp_cur = '0;
        device_req_i = 1'b0; device_we_i = 1'b0; device_addr_i = '0;
        device_be_i = '0; device_wdata_i = '0; gp_i = '0;
        #2;
        do_reset();

        // Byte-masked OUT write, then SET and CLR
        wr(32'h00, 4'b0011, 32'h1234); chk("out_wr", 32'(gp_o), 32'h1234);
        wr(32'h04, 4'b1111, 32'h00F0); chk("out_set", 32'(gp_o), 32'h12F4);
        wr(32'h08, 4'b1111, 32'h0204); chk("out_clr", 32'(gp_o), 32'h10F0);

        // Single-lane write, unmapped read, address aliasing
        do_reset();
        wr(32'h00, 4'b0001, 32'hFFFF); chk("out_lane0", 32'(gp_o), 32'h00FF);
        rd(32'h3FC);                   chk("unmapped_rd", last_rdata, 32'h0);
        wr(32'h400, 4'hF, 32'hABCD);   chk("alias_wr", 32'(gp_o), 32'hABCD);
        rd(32'hFFFF_FC02);             chk("alias_rd", last_rdata, 32'hABCD);

        // Rising edge on gp_i[0]: IN two edges later, irq one edge after that
        wr(32'h10, 4'hF, 32'h1);
        gp_cur = 16'h0001;
        idle(1);       chk("irq_e0", 32'(irq_o), 32'h0);
        rd(32'h0C);    chk("irq_e1", 32'(irq_o), 32'h0); chk("in_e1", last_rdata, 32'h0);
        rd(32'h0C);    chk("irq_e2", 32'(irq_o), 32'h1); chk("in_e2", last_rdata, 32'h1);
        wr(32'h18, 4'b0000, 32'h1); chk("w1c_no_be", 32'(irq_o), 32'h1);
        wr(32'h18, 4'hF, 32'h1);    chk("w1c_clear", 32'(irq_o), 32'h0);

        // Falling edge on gp_i[1] landing with a W1C of the same bit: set wins
        wr(32'h14, 4'hF, 32'h2);
        gp_cur = 16'h0003;
        idle(4);       chk("no_rise_irq", 32'(irq_o), 32'h0);
        gp_cur = 16'h0001;
        idle(2);
        wr(32'h18, 4'hF, 32'h2);    chk("set_wins_irq", 32'(irq_o), 32'h1);
        rd(32'h18);                 chk("set_wins_stat", last_rdata, 32'h2);
        wr(32'h14, 4'hF, 32'h0);    chk("en_clr_keeps", 32'(irq_o), 32'h1);

        // Reset in the middle of activity, then inputs held high across release
        wr(32'h00, 4'hF, 32'hFFFF);
        gp_cur = 16'hFFFF;
        do_reset();
        idle(2);
        rd(32'h0C);                 chk("in_after_rst", last_rdata, 32'hFFFF);
        idle(2);                    chk("irq_after_rst", 32'(irq_o), 32'h0);

`ifdef GPIO_CTRL_DEBOUNCE_EN
        // Debounce length 4: 3-cycle glitch rejected, 4-cycle pulse passes 4 edges late
        gp_cur = '0;
        idle(6);
        wr(32'h1C, 4'hF, 32'h4);
        rd(32'h1C);                 chk("dbnc_rd", last_rdata, 32'h4);
        for (int i = 0; i < 10; i++) begin
            gp_cur = (i < 3) ? 16'h0004 : 16'h0000;
            rd(32'h0C);
            chk("dbnc_short", 32'(last_rdata[2]), 32'h0);
        end
        idle(4);
        for (int i = 0; i < 8; i++) begin
            gp_cur = (i < 4) ? 16'h0004 : 16'h0000;
            rd(32'h0C);
            if (i == 5) chk("dbnc_long_e5", 32'(last_rdata[2]), 32'h0);
            if (i == 6) chk("dbnc_long_e6", 32'(last_rdata[2]), 32'h1);
        end
`endif

        // Randomised bus traffic and pin activity against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r, ra, a, d;
            logic [7:0]  w;
            if (n == 700) do_reset();
            r  = $urandom();
            ra = $urandom();
            w  = (r[3:0] < 4'd13) ? {5'd0, r[6:4]} : r[15:8];
            a  = {ra[31:10], w, ra[1:0]};
            d  = $urandom();
            if (w == 8'd7) d = $urandom_range(0, 5);
            if (r[20:18] == 3'd0) gp_cur = gp_cur ^ (16'($urandom()) & 16'($urandom()));
            step(r[24], r[25], a, r[29:26], d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
